// File: rtl/pipemdu.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers for the EXE stage.
// Define MDU_SIGNED_EN to make MULT/DIV signed; otherwise they alias MULTU/DIVU.
module pipemdu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNTW  = 5
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             estart,
   input  logic [2:0]       emduop,
   input  logic [WIDTH-1:0] ea,
   input  logic [WIDTH-1:0] eb,
   input  logic             ecancel,
   output logic             ebusy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             edone
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   typedef enum logic [2:0] {
      OP_NONE  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIVU  = 3'b010,
      OP_MULT  = 3'b011,
      OP_DIV   = 3'b100,
      OP_MTHI  = 3'b101,
      OP_MTLO  = 3'b110,
      OP_RSVD  = 3'b111
   } mduop_t;

   localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

   state_t           state;
   mduop_t           op;
   logic [CNTW-1:0]  cnt;
   logic [WIDTH-1:0] acc;   // partial product high half / remainder
   logic [WIDTH-1:0] q;     // multiplier (shifts out) / dividend -> quotient
   logic [WIDTH-1:0] d;     // multiplicand / divisor
   logic             isdiv;
   logic             dz;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     msum, rsh, rdiff;
   logic [WIDTH-1:0]   step_acc, step_q;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
   logic               div_op;

   assign op     = mduop_t'(emduop);
   assign div_op = (op == OP_DIVU) || (op == OP_DIV);

`ifdef MDU_SIGNED_EN
   logic sa, sb, sgn_op;
   assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
   always_comb begin
      mag_a = (sgn_op && ea[WIDTH-1]) ? -ea : ea;
      mag_b = (sgn_op && eb[WIDTH-1]) ? -eb : eb;
   end
`else
   always_comb begin
      mag_a = ea;
      mag_b = eb;
   end
`endif

   always_comb begin
      msum  = {1'b0, acc} + (q[0] ? {1'b0, d} : '0);
      rsh   = {acc, q[WIDTH-1]};
      rdiff = rsh - {1'b0, d};
      if (isdiv) begin
         if (!rdiff[WIDTH]) begin
            step_acc = rdiff[WIDTH-1:0];
            step_q   = {q[WIDTH-2:0], 1'b1};
         end else begin
            step_acc = rsh[WIDTH-1:0];
            step_q   = {q[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_acc = msum[WIDTH:1];
         step_q   = {msum[0], q[WIDTH-1:1]};
      end
   end

   // With a zero divisor every trial subtract succeeds, so the remainder ends up
   // holding the full dividend; only the quotient needs the all-ones override.
   always_comb begin
      prod = {acc, q};
      quo  = q;
      rem  = acc;
`ifdef MDU_SIGNED_EN
      if (sa ^ sb) begin
         prod = -prod;
         quo  = -quo;
      end
      if (sa) rem = -rem;
`endif
      if (dz) quo = '1;
      res_hi = isdiv ? rem : prod[2*WIDTH-1:WIDTH];
      res_lo = isdiv ? quo : prod[WIDTH-1:0];
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
         acc   <= '0;
         q     <= '0;
         d     <= '0;
         isdiv <= 1'b0;
         dz    <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         ebusy <= 1'b0;
         edone <= 1'b0;
`ifdef MDU_SIGNED_EN
         sa    <= 1'b0;
         sb    <= 1'b0;
`endif
      end else if (ecancel) begin
         state <= IDLE;
         cnt   <= '0;
         ebusy <= 1'b0;
         edone <= 1'b0;
      end else begin
         edone <= 1'b0;
         case (state)
            IDLE: begin
               if (estart) begin
                  case (op)
                     OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                        q     <= mag_a;
                        d     <= mag_b;
                        acc   <= '0;
                        cnt   <= '0;
                        isdiv <= div_op;
                        dz    <= div_op && (eb == '0);
`ifdef MDU_SIGNED_EN
                        sa    <= sgn_op && ea[WIDTH-1];
                        sb    <= sgn_op && eb[WIDTH-1];
`endif
                        state <= RUN;
                        ebusy <= 1'b1;
                     end
                     OP_MTHI: hi <= ea;
                     OP_MTLO: lo <= ea;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               acc <= step_acc;
               q   <= step_q;
               cnt <= cnt + CNTW'(1);
               if (cnt == LAST) state <= FIX;
            end
            FIX: begin
               hi    <= res_hi;
               lo    <= res_lo;
               edone <= 1'b1;
               ebusy <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               ebusy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipemdu.sv
// Bench for pipemdu: directed corner cases plus random ops against a 64-bit arithmetic model.
// Expectations follow MDU_SIGNED_EN the same way the design does.
module tb_pipemdu;

   localparam logic [2:0] MULTU = 3'b001, DIVU = 3'b010, MULT = 3'b011,
                          DIV = 3'b100, MTHI = 3'b101, MTLO = 3'b110;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        estart = 1'b0;
   logic [2:0]  emduop = 3'b000;
   logic [31:0] ea = '0, eb = '0;
   logic        ecancel = 1'b0;
   logic        ebusy, edone;
   logic [31:0] hi, lo;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_hi = '0, exp_lo = '0;

   pipemdu #(.WIDTH(32), .CNTW(5)) dut (
      .clock(clock), .resetn(resetn), .estart(estart), .emduop(emduop),
      .ea(ea), .eb(eb), .ecancel(ecancel), .ebusy(ebusy), .hi(hi), .lo(lo),
      .edone(edone)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl);
      logic        sgn;
      logic [63:0] p;
      longint      sa, sb, sq, sr;
`ifdef MDU_SIGNED_EN
      sgn = (op == MULT) || (op == DIV);
`else
      sgn = 1'b0;
`endif
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op == MULTU || op == MULT) begin
         if (sgn) p = 64'(sa * sb);
         else     p = {32'b0, a} * {32'b0, b};
         rh = p[63:32];
         rl = p[31:0];
      end else if (b == 32'd0) begin
         rh = a;
         rl = 32'hFFFF_FFFF;
      end else if (sgn) begin
         sq = sa / sb;
         sr = sa % sb;
         rh = sr[31:0];
         rl = sq[31:0];
      end else begin
         rh = a % b;
         rl = a / b;
      end
   endfunction

   // Issue one mul/div op, optionally poke a stray MULTU at busy cycle inj, check timing and result.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int inj);
      int n = 0;
      int ed = 0;
      model(op, a, b, exp_hi, exp_lo);
      @(negedge clock);
      estart = 1'b1; emduop = op; ea = a; eb = b;
      @(negedge clock);
      estart = 1'b0; emduop = 3'b000; ea = $urandom; eb = $urandom;
      while (ebusy === 1'b1 && n < 40) begin
         if (edone !== 1'b0) ed++;
         n++;
         if (n == inj) begin
            estart = 1'b1; emduop = MULTU; ea = $urandom; eb = $urandom;
         end else begin
            estart = 1'b0; emduop = 3'b000;
         end
         @(negedge clock);
      end
      estart = 1'b0;
      chk({tag, ".busy_cycles"}, 32'(n), 32'd33);
      chk({tag, ".edone_early"}, 32'(ed), 32'd0);
      chk({tag, ".edone"}, 32'(edone), 32'd1);
      chk({tag, ".hi"}, hi, exp_hi);
      chk({tag, ".lo"}, lo, exp_lo);
      @(negedge clock);
      chk({tag, ".edone_drop"}, 32'(edone), 32'd0);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          ed;

      repeat (2) @(negedge clock);
      chk("reset.ebusy", 32'(ebusy), 32'd0);
      chk("reset.edone", 32'(edone), 32'd0);
      chk("reset.hi", hi, 32'd0);
      chk("reset.lo", lo, 32'd0);
      resetn = 1'b1;

      run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'h2, -1);
      chk("multu_max.hi_const", hi, 32'h1);
      chk("multu_max.lo_const", lo, 32'hFFFF_FFFE);
      run_op("divu_100_7", DIVU, 32'd100, 32'd7, -1);
      chk("divu_100_7.hi_const", hi, 32'd2);
      chk("divu_100_7.lo_const", lo, 32'd14);
      run_op("divu_zero", DIVU, 32'd5, 32'd0, -1);
      chk("divu_zero.hi_const", hi, 32'd5);
      chk("divu_zero.lo_const", lo, 32'hFFFF_FFFF);

      // MTHI then MTLO on back-to-back cycles
      @(negedge clock);
      estart = 1'b1; emduop = MTHI; ea = 32'h1234_5678;
      @(negedge clock);
      chk("mthi.hi", hi, 32'h1234_5678);
      chk("mthi.ebusy", 32'(ebusy), 32'd0);
      emduop = MTLO; ea = 32'hCAFE_F00D;
      @(negedge clock);
      estart = 1'b0; emduop = 3'b000;
      chk("mtlo.lo", lo, 32'hCAFE_F00D);
      chk("mtlo.hi_kept", hi, 32'h1234_5678);
      chk("mtlo.ebusy", 32'(ebusy), 32'd0);
      chk("mtlo.edone", 32'(edone), 32'd0);

      run_op("mult_m3_5", MULT, 32'hFFFF_FFFD, 32'd5, -1);
`ifdef MDU_SIGNED_EN
      chk("mult_m3_5.hi_const", hi, 32'hFFFF_FFFF);
`else
      chk("mult_m3_5.hi_const", hi, 32'd4);
`endif
      chk("mult_m3_5.lo_const", lo, 32'hFFFF_FFF1);
      run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, -1);
`ifdef MDU_SIGNED_EN
      chk("div_m7_2.hi_const", hi, 32'hFFFF_FFFF);
      chk("div_m7_2.lo_const", lo, 32'hFFFF_FFFD);
`else
      chk("div_m7_2.hi_const", hi, 32'd1);
      chk("div_m7_2.lo_const", lo, 32'h7FFF_FFFC);
`endif

      // stray estart during busy must not disturb the divide
      run_op("divu_inject", DIVU, 32'hDEAD_BEEF, 32'd12345, 5);

      // cancel at RUN cycle 10: HI/LO hold, no edone ever
      exp_hi = hi; exp_lo = lo;
      @(negedge clock);
      estart = 1'b1; emduop = MULTU; ea = 32'h0BAD_F00D; eb = 32'h7777_1111;
      @(negedge clock);
      estart = 1'b0; emduop = 3'b000;
      repeat (9) @(negedge clock);
      chk("cancel.busy_before", 32'(ebusy), 32'd1);
      ecancel = 1'b1;
      @(negedge clock);
      ecancel = 1'b0;
      chk("cancel.ebusy", 32'(ebusy), 32'd0);
      ed = 0;
      for (int i = 0; i < 40; i++) begin
         if (edone !== 1'b0 || ebusy !== 1'b0) ed++;
         @(negedge clock);
      end
      chk("cancel.no_activity", 32'(ed), 32'd0);
      chk("cancel.hi", hi, exp_hi);
      chk("cancel.lo", lo, exp_lo);

      // cancel wins over a simultaneous start or MTHI
      estart = 1'b1; emduop = MULTU; ea = 32'd3; eb = 32'd3; ecancel = 1'b1;
      @(negedge clock);
      chk("cancel_start.ebusy", 32'(ebusy), 32'd0);
      emduop = MTHI; ea = 32'h5555_AAAA;
      @(negedge clock);
      estart = 1'b0; ecancel = 1'b0; emduop = 3'b000;
      chk("cancel_mthi.hi", hi, exp_hi);

      // random operations against the model
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(3, 0))
            0: rop = MULTU;
            1: rop = DIVU;
            2: rop = MULT;
            default: rop = DIV;
         endcase
         ra = $urandom;
         case ($urandom_range(3, 0))
            0: rb = 32'(($urandom_range(2, 0)));
            1: rb = 32'hFFFF_FFFF - 32'($urandom_range(3, 0));
            default: rb = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), rop, ra, rb, -1);
      end

      // asynchronous reset mid-RUN clears everything without a clock edge
      run_op("pre_reset", MULTU, 32'hFFFF_0001, 32'h0001_FFFF, -1);
      @(negedge clock);
      estart = 1'b1; emduop = DIVU; ea = 32'h8000_0000; eb = 32'd3;
      @(negedge clock);
      estart = 1'b0; emduop = 3'b000;
      repeat (7) @(negedge clock);
      #2 resetn = 1'b0;
      #1;
      chk("areset.ebusy", 32'(ebusy), 32'd0);
      chk("areset.edone", 32'(edone), 32'd0);
      chk("areset.hi", hi, 32'd0);
      chk("areset.lo", lo, 32'd0);
      @(negedge clock);
      resetn = 1'b1;
      run_op("post_reset", DIVU, 32'd1000, 32'd33, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
